// File: rtl/neureka_pe_reduce_pipe.sv
// PE reduction stage: pipelined signed adder tree over N_COL columns, multi-beat accumulator,
// depthwise pass-through. Define NEUREKA_PE_REDUCE_SAT_EN for a saturating, sticky accumulator.
module neureka_pe_reduce_pipe #(
    parameter int N_COL       = 32,
    parameter int IN_W        = 22,
    parameter int PIPE_STAGES = 1,
    parameter int ACC_EXT     = 4,
    localparam int ACC_W      = IN_W + $clog2(N_COL) + ACC_EXT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [N_COL*IN_W-1:0]   col_data_i,
    input  logic [N_COL-1:0]        col_en_i,
    input  logic                    pad_i,
    input  logic [ACC_W-1:0]        pad_value_i,
    input  logic                    dw_mode_i,
    input  logic [7:0]              acc_len_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ACC_W-1:0]        out_data_o,
    output logic                    dw_valid_o,
    output logic [N_COL*IN_W-1:0]   dw_data_o
);

    localparam int LVLS = $clog2(N_COL);
    localparam int NP   = 1 << LVLS;

    // Register after tree level floor((k+1)*LVLS/(PIPE_STAGES+1)); spreads the stages evenly.
    function automatic logic [LVLS:0] reg_mask_f();
        logic [LVLS:0] m;
        m = '0;
        for (int k = 0; k < PIPE_STAGES; k++) m[((k+1)*LVLS)/(PIPE_STAGES+1)] = 1'b1;
        return m;
    endfunction
    localparam logic [LVLS:0] REG_MASK = reg_mask_f();

    typedef struct packed {
        logic                  valid;
        logic                  dw;
        logic                  pad;
        logic                  first;
        logic                  last;
        logic [ACC_W-1:0]      pad_value;
        logic [N_COL*IN_W-1:0] dw_data;
    } beat_t;

    // Handshake: a beat moves on valid&ready; the whole pipe freezes while an output waits.
    logic stall, accept;
    assign stall      = (out_valid_o | dw_valid_o) & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign accept     = in_valid_i & ~stall & ~clear_i;

    logic [7:0] cnt_q, len_q, len_eff;
    logic       first_beat, last_beat;
    assign len_eff    = (cnt_q != 8'd0) ? len_q : ((acc_len_i == 8'd0) ? 8'd1 : acc_len_i);
    assign first_beat = (cnt_q == 8'd0);
    assign last_beat  = (cnt_q == len_eff - 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
            len_q <= '0;
        end else if (accept && !dw_mode_i) begin
            if (first_beat) len_q <= len_eff;
            cnt_q <= last_beat ? 8'd0 : cnt_q + 8'd1;
        end
    end

    logic [N_COL*IN_W-1:0]             col_masked;
    logic [LVLS:0][NP-1:0][ACC_W-1:0]  tree_c, tree_s, tree_q;
    logic [ACC_W-1:0]                  sum;

    always_comb begin
        col_masked = '0;
        tree_c     = '0;
        tree_s     = '0;
        for (int i = 0; i < N_COL; i++)
            if (col_en_i[i]) col_masked[i*IN_W +: IN_W] = col_data_i[i*IN_W +: IN_W];
        for (int i = 0; i < N_COL; i++)
            if (!pad_i) tree_c[0][i] = ACC_W'($signed(col_masked[i*IN_W +: IN_W]));
        tree_s[0] = REG_MASK[0] ? tree_q[0] : tree_c[0];
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (NP >> l); i++)
                tree_c[l][i] = tree_s[l-1][2*i] + tree_s[l-1][2*i+1];
            tree_s[l] = REG_MASK[l] ? tree_q[l] : tree_c[l];
        end
    end
    assign sum = tree_s[LVLS][0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      tree_q <= '0;
        else if (!stall)  tree_q <= tree_c;
    end

    beat_t sb_in, sb_out;
    always_comb begin
        sb_in           = '0;
        sb_in.valid     = accept;
        sb_in.dw        = dw_mode_i;
        sb_in.pad       = pad_i;
        sb_in.first     = first_beat;
        sb_in.last      = last_beat;
        sb_in.pad_value = pad_value_i;
        sb_in.dw_data   = col_masked;
    end

    // Sideband travels alongside the tree registers so each beat keeps its own mode and flags.
    if (PIPE_STAGES > 0) begin : g_sb
        beat_t sb_q [PIPE_STAGES];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < PIPE_STAGES; i++) sb_q[i] <= '0;
            end else if (clear_i) begin
                for (int i = 0; i < PIPE_STAGES; i++) sb_q[i] <= '0;
            end else if (!stall) begin
                sb_q[0] <= sb_in;
                for (int i = 1; i < PIPE_STAGES; i++) sb_q[i] <= sb_q[i-1];
            end
        end
        assign sb_out = sb_q[PIPE_STAGES-1];
    end else begin : g_no_sb
        assign sb_out = sb_in;
    end

    logic [ACC_W-1:0] acc_q, acc_next;
`ifdef NEUREKA_PE_REDUCE_SAT_EN
    logic           sat_q, sat_next;
    logic [ACC_W:0] wide;
    always_comb begin
        sat_next = sat_q;
        wide     = {sum[ACC_W-1], sum} + {acc_q[ACC_W-1], acc_q};
        if (sb_out.first) begin
            acc_next = sum;
            sat_next = 1'b0;
        end else if (sat_q) begin
            acc_next = acc_q;
        end else if (wide[ACC_W] != wide[ACC_W-1]) begin
            acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            sat_next = 1'b1;
        end else begin
            acc_next = wide[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        acc_next = sb_out.first ? sum : acc_q + sum;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_i) begin
            out_valid_o <= 1'b0;
            dw_valid_o  <= 1'b0;
            out_data_o  <= '0;
            dw_data_o   <= '0;
            acc_q       <= '0;
`ifdef NEUREKA_PE_REDUCE_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid_o <= 1'b0;
            dw_valid_o  <= 1'b0;
            if (sb_out.valid) begin
                if (sb_out.dw) begin
                    dw_valid_o <= 1'b1;
                    dw_data_o  <= sb_out.dw_data;
                end else if (sb_out.last) begin
                    out_valid_o <= 1'b1;
                    out_data_o  <= sb_out.pad ? sb_out.pad_value : acc_next;
                    acc_q       <= '0;
`ifdef NEUREKA_PE_REDUCE_SAT_EN
                    sat_q       <= 1'b0;
`endif
                end else begin
                    acc_q <= acc_next;
`ifdef NEUREKA_PE_REDUCE_SAT_EN
                    sat_q <= sat_next;
`endif
                end
            end
        end
    end

endmodule
